// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU and its handshaked execution wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: opcode constants and the packed response record stored per FIFO entry.
package alu4_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  // One queued response: result nibble followed by carry, negative, zero, overflow.
  typedef struct packed {
    logic [3:0] result;
    logic       c;
    logic       n;
    logic       z;
    logic       v;
  } rsp_t;

endpackage

// File: rtl/alu4.sv
// Purpose: combinational 4-bit ALU producing result and c/n/z/v flags.
// Latency: zero cycles (purely combinational).
// Backpressure: none; output follows the inputs continuously.
//
// Ports:
//   i_op      opcode (see alu4_pkg)
//   i_a, i_b  4-bit operands
//   o_result  4-bit result
//   o_c/o_n/o_z/o_v  carry, negative, zero, signed-overflow flags
module alu4
  import alu4_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_result,
  output logic       o_c,
  output logic       o_n,
  output logic       o_z,
  output logic       o_v
);

  logic [4:0] w_sum;
  logic [4:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // Subtraction as a + ~b + 1 so the carry out means "no borrow".
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + 5'd1;

  always_comb begin
    o_result = '0;
    o_c      = 1'b0;
    o_v      = 1'b0;
    case (i_op)
      OP_NOTA: o_result = ~i_a;
      OP_NOTB: o_result = ~i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_XNOR: o_result = ~(i_a ^ i_b);
      OP_ADD: begin
        {o_c, o_result} = w_sum;
        o_v = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
      end
      OP_SUB: begin
        {o_c, o_result} = w_dif;
        o_v = (i_a[3] != i_b[3]) && (w_dif[3] != i_a[3]);
      end
      default: o_result = '0;
    endcase
  end

  assign o_n = o_result[3];
  assign o_z = (o_result == 4'd0);

endmodule

// File: rtl/alu4_exec_unit.sv
// Purpose: valid/ready execution wrapper around alu4 with an in-order response FIFO.
// Latency: request accepted at edge k into an empty FIFO is visible on rsp_* in cycle k+1.
// Backpressure: req_ready = (count < DEPTH) from registered count only; no path from rsp_ready.
//
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   req_valid/req_ready           request handshake; req_op/req_a/req_b sampled on accept
//   rsp_valid/rsp_ready           response handshake; rsp_result/c/n/z/v show FIFO head
//   op_count                      accepted-request counter, wraps modulo 2^CNT_W
//   ovf_sticky                    set by any accepted ADD/SUB with v=1, cleared by reset
module alu4_exec_unit
  import alu4_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_c,
  output logic             rsp_n,
  output logic             rsp_z,
  output logic             rsp_v,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_sticky
);

  localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  rsp_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [CNT_W-1:0] r_op_count;
  logic             r_ovf_sticky;

  rsp_t             w_alu_rsp;
  rsp_t             w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_is_arith;

  alu4 u_alu4 (
    .i_op     (req_op),
    .i_a      (req_a),
    .i_b      (req_b),
    .o_result (w_alu_rsp.result),
    .o_c      (w_alu_rsp.c),
    .o_n      (w_alu_rsp.n),
    .o_z      (w_alu_rsp.z),
    .o_v      (w_alu_rsp.v)
  );

  assign req_ready  = (r_count < DEPTH_C);
  assign rsp_valid  = (r_count != '0);
  assign w_push     = req_valid && req_ready;
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_is_arith = (req_op == OP_ADD) || (req_op == OP_SUB);

  // Storage is not reset; an empty FIFO forces the outputs to zero so stale
  // entries left behind by a reset are never visible.
  assign w_head     = rsp_valid ? r_mem[r_rd_ptr] : '0;
  assign rsp_result = w_head.result;
  assign rsp_c      = w_head.c;
  assign rsp_n      = w_head.n;
  assign rsp_z      = w_head.z;
  assign rsp_v      = w_head.v;

  assign op_count   = r_op_count;
  assign ovf_sticky = r_ovf_sticky;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_alu_rsp;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_op_count   <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_op_count <= r_op_count + CNT_W'(1);
        if (w_is_arith && w_alu_rsp.v) begin
          r_ovf_sticky <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_exec_unit.sv
// Purpose: self-checking bench for alu4_exec_unit using an integer-arithmetic reference and a queue scoreboard.
// Latency: n/a (testbench).
// Backpressure: exercised by randomised and directed rsp_ready patterns.
module tb_alu4_exec_unit;
  import alu4_pkg::*;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [3:0]       req_a;
  logic [3:0]       req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_result;
  logic             rsp_c, rsp_n, rsp_z, rsp_v;
  logic [CNT_W-1:0] op_count;
  logic             ovf_sticky;
  logic [7:0]       w_obs;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt = 0;
  logic       exp_ovf = 1'b0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  assign w_obs = {rsp_result, rsp_c, rsp_n, rsp_z, rsp_v};

  alu4_exec_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_c      (rsp_c),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z),
    .rsp_v      (rsp_v),
    .op_count   (op_count),
    .ovf_sticky (ovf_sticky)
  );

  // Reference: operands as unsigned and signed integers, flags from range checks.
  function automatic logic [7:0] ref_rsp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int   ua, ub, sa, sb, r, s;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    r = 0; s = 0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: r = 15 - ua;
      3'd1: r = 15 - ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 15 - (ua ^ ub);
      3'd6: begin
        r = (ua + ub) % 16;
        c = ((ua + ub) > 15);
        s = sa + sb;
        v = (s > 7) || (s < -8);
      end
      default: begin
        r = (ua - ub + 16) % 16;
        c = (ua >= ub);
        s = sa - sb;
        v = (s > 7) || (s < -8);
      end
    endcase
    return {4'(r), c, (r > 7), (r == 0), v};
  endfunction

  task automatic test_reset;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 4'd0;
    req_b     = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (op_count !== '0) begin n_bad++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_sticky: got %b expected 0", ovf_sticky); end
    n_cmp++; if (w_obs !== 8'h00) begin n_bad++; $display("FAIL reset_rsp_bits: got %b expected 00000000", w_obs); end
  endtask

  task automatic test_opcodes;
    logic [2:0] t_op  [6] = '{OP_NOTA, OP_AND, OP_XNOR, OP_ADD, OP_SUB, OP_SUB};
    logic [3:0] t_a   [6] = '{4'b0000, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0010};
    logic [3:0] t_b   [6] = '{4'b0000, 4'b1010, 4'b0011, 4'b0011, 4'b0010, 4'b0101};
    // {result, c, n, z, v}
    logic [7:0] t_exp [6] = '{8'b1111_0100, 8'b0000_0010, 8'b1001_0100,
                              8'b1000_0101, 8'b0011_1000, 8'b1101_0100};
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_op    = t_op[i];
      req_a     = t_a[i];
      req_b     = t_b[i];
      rsp_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      req_valid = 1'b0;
      n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL opcode_%0d_valid: got %b expected 1", i, rsp_valid); end
      n_cmp++; if (w_obs !== t_exp[i]) begin n_bad++; $display("FAIL opcode_%0d_rsp: got %b expected %b", i, w_obs, t_exp[i]); end
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL opcode_%0d_pop: rsp_valid %b expected 0", i, rsp_valid); end
    end
    exp_ovf = 1'b1;
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_bad++; $display("FAIL opcodes_ovf_sticky: got %b expected 1", ovf_sticky); end
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL opcodes_op_count: got %0d expected %0d", op_count, exp_cnt); end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_ADD; req_a = 4'b0001; req_b = 4'b0001;
    @(negedge clk);
    exp_cnt++;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_1: got %b expected 1", req_ready); end
    req_op = OP_OR; req_a = 4'b1100; req_b = 4'b0011;
    @(negedge clk);
    exp_cnt++;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b expected 0", req_ready); end
    req_op = OP_XOR; req_a = 4'b1111; req_b = 4'b0101;
    @(negedge clk);
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL bp_third_held: op_count %0d expected %0d", op_count, exp_cnt); end
    n_cmp++; if (w_obs !== 8'b0010_0000) begin n_bad++; $display("FAIL bp_head_add: got %b expected 00100000", w_obs); end
    // Pop while full: req_ready stays low for this edge, so XOR is still held.
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (w_obs !== 8'b1111_0100) begin n_bad++; $display("FAIL bp_head_or: got %b expected 11110100", w_obs); end
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL bp_no_accept_on_full_pop: op_count %0d expected %0d", op_count, exp_cnt); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %b expected 1", req_ready); end
    @(negedge clk);
    exp_cnt++;
    req_valid = 1'b0;
    n_cmp++; if (w_obs !== 8'b1010_0100) begin n_bad++; $display("FAIL bp_head_xor: got %b expected 10100100", w_obs); end
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL bp_op_count: got %0d expected %0d", op_count, exp_cnt); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_streaming;
    logic [7:0] prev;
    logic [3:0] a, b;
    prev = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        n_cmp++; if (rsp_valid !== 1'b1 || w_obs !== prev) begin n_bad++; $display("FAIL stream_%0d: valid %b rsp %b expected valid 1 rsp %b", i, rsp_valid, w_obs, prev); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL stream_%0d_ready: got %b expected 1", i, req_ready); end
      end
      if (i < 16) begin
        a = 4'($urandom);
        b = 4'($urandom);
        req_valid = 1'b1; req_op = OP_ADD; req_a = a; req_b = b;
        prev = ref_rsp(OP_ADD, a, b);
        exp_cnt++;
        if (prev[0]) exp_ovf = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drained: rsp_valid %b expected 0", rsp_valid); end
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL stream_op_count: got %0d expected %0d", op_count, exp_cnt); end
  endtask

  task automatic test_stall_hold;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_ADD; req_a = 4'b0100; req_b = 4'b0100;
    @(negedge clk);
    exp_cnt++;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || w_obs !== 8'b1000_0101) begin n_bad++; $display("FAIL stall_%0d: valid %b rsp %b expected valid 1 rsp 10000101", i, rsp_valid, w_obs); end
      req_a  = 4'($urandom);
      req_b  = 4'($urandom);
      req_op = 3'($urandom);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: rsp_valid %b expected 0", rsp_valid); end
  endtask

  task automatic test_async_reset;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_ADD; req_a = 4'b0111; req_b = 4'b0001;
    @(negedge clk);
    req_op = OP_OR; req_a = 4'b0011;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL areset_prefill: ready %b valid %b expected 0 1", req_ready, rsp_valid); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL areset_rsp_valid: got %b expected 0", rsp_valid); end
    n_cmp++; if (w_obs !== 8'h00) begin n_bad++; $display("FAIL areset_rsp_bits: got %b expected 00000000", w_obs); end
    n_cmp++; if (op_count !== '0) begin n_bad++; $display("FAIL areset_op_count: got %0d expected 0", op_count); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_bad++; $display("FAIL areset_ovf: got %b expected 0", ovf_sticky); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0;
    exp_ovf = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL areset_after_release: valid %b ready %b expected 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_wrap;
    int         accepted;
    int         cycles;
    logic       push, pop;
    logic [7:0] exp;
    accepted = 0;
    cycles   = 0;
    while (accepted < 256 && cycles < 4000) begin
      n_cmp++; if (req_ready !== (sb_q.size() < DEPTH)) begin n_bad++; $display("FAIL wrap_ready_c%0d: got %b expected %b", cycles, req_ready, (sb_q.size() < DEPTH)); end
      n_cmp++; if (rsp_valid !== (sb_q.size() > 0)) begin n_bad++; $display("FAIL wrap_valid_c%0d: got %b expected %b", cycles, rsp_valid, (sb_q.size() > 0)); end
      if (sb_q.size() > 0) begin
        n_cmp++; if (w_obs !== sb_q[0]) begin n_bad++; $display("FAIL wrap_head_c%0d: got %b expected %b", cycles, w_obs, sb_q[0]); end
      end
      n_cmp++; if (ovf_sticky !== exp_ovf) begin n_bad++; $display("FAIL wrap_ovf_c%0d: got %b expected %b", cycles, ovf_sticky, exp_ovf); end
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      req_op    = 3'($urandom);
      req_a     = 4'($urandom);
      req_b     = 4'($urandom);
      push = req_valid && (sb_q.size() < DEPTH);
      pop  = rsp_ready && (sb_q.size() > 0);
      if (pop) void'(sb_q.pop_front());
      if (push) begin
        exp = ref_rsp(req_op, req_a, req_b);
        sb_q.push_back(exp);
        accepted++;
        exp_cnt++;
        if ((req_op == OP_ADD || req_op == OP_SUB) && exp[0]) exp_ovf = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    if (accepted < 256) begin
      n_cmp++; n_bad++;
      $display("FAIL wrap_timeout: accepted %0d expected 256 within 4000 cycles", accepted);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1 && sb_q.size() > 0; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || w_obs !== sb_q[0]) begin n_bad++; $display("FAIL wrap_drain_%0d: valid %b rsp %b expected valid 1 rsp %b", i, rsp_valid, w_obs, sb_q[0]); end
      void'(sb_q.pop_front());
      @(negedge clk);
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: rsp_valid %b expected 0", rsp_valid); end
    n_cmp++; if (op_count !== CNT_W'(exp_cnt)) begin n_bad++; $display("FAIL wrap_op_count: got %0d expected %0d", op_count, CNT_W'(exp_cnt)); end
    n_cmp++; if (ovf_sticky !== exp_ovf) begin n_bad++; $display("FAIL wrap_ovf_final: got %b expected %b", ovf_sticky, exp_ovf); end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_backpressure();
    test_streaming();
    test_stall_hold();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu4_exec_unit.md
Name: alu4_exec_unit

Overview:
Sequential, handshaked execution wrapper around the 4-bit combinational ALU (alu4).
- Accepts operation requests (op, a, b) on a valid/ready request channel.
- Computes result and flags (c, n, z, v) and queues them in an in-order response FIFO.
- Returns them on a valid/ready response channel.
- It is the responder end of the ALU command interface, used by sequencers and hardware stimulus/check logic.

Parameters:
DEPTH, 2, response FIFO entries; power of two, ≥2.
CNT_W, 8, width of the accepted-operation counter.

Ports:
clk  input  1  single clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request this cycle
req_op  input  3  opcode: 000 NOT A, 001 NOT B, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ADD, 111 SUB
req_a  input  4  operand A
req_b  input  4  operand B
rsp_valid  output  1  head-of-FIFO response present
rsp_ready  input  1  consumer takes the response
rsp_result  output  4  result at FIFO head
rsp_c  output  1  carry flag at head
rsp_n  output  1  negative flag at head
rsp_z  output  1  zero flag at head
rsp_v  output  1  overflow flag at head
op_count  output  CNT_W  number of accepted requests, wraps modulo 2^CNT_W
ovf_sticky  output  1  set when any accepted ADD/SUB produced v=1; cleared only by reset

Behaviour:
- Reset (reset_n=0, asynchronous): FIFO empty and pointers at 0.
  - Outputs: req_ready=1 (once released), rsp_valid=0, rsp_result=0, rsp_c/n/z/v=0, op_count=0, ovf_sticky=0.
  - Reset mid-operation discards all queued responses. No partial response survives.
- Accept when req_valid && req_ready on a rising edge. Operands are sampled on that edge. Later operand changes have no effect.
- req_ready = (count < DEPTH). It is purely a function of registered count, with no combinational path from rsp_ready. A full FIFO with a simultaneous pop still deasserts req_ready that cycle.
- Pop when rsp_valid && rsp_ready. rsp_* always reflect the FIFO head; they hold stable while rsp_valid=1 and rsp_ready=0.
- Latency: a request accepted at edge k into an empty FIFO gives rsp_valid=1 after edge k (visible in cycle k+1).
- Throughput: 1 op/cycle when rsp_ready is held high.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into empty with pop is not possible (rsp_valid=0).
- Pointers wrap modulo DEPTH. Count is tracked to DEPTH inclusive, with log2(DEPTH)+1 bits.
- Responses return strictly in acceptance order.
- Flag rules, computed from 4-bit values:
  - n = result[3].
  - z = (result == 0).
  - Logic ops (000–101): c=0, v=0.
  - ADD: {c,result} = a + b. v = (a[3]==b[3]) && (result[3]!=a[3]).
  - SUB: computed as a + ~b + 1. c = carry out (1 means no borrow, i.e. a ≥ b unsigned). v = (a[3]!=b[3]) && (result[3]!=a[3]).
- op_count increments by 1 on every accept and wraps from all-ones to 0.
- ovf_sticky is set on the edge that accepts an ADD/SUB with v=1.

Decomposition:
- Shared package alu4_pkg holds:
  - opcode constants OP_NOTA..OP_SUB (3-bit);
  - a packed response typedef {result[3:0], c, n, z, v} (8 bits), used as the FIFO entry.
- Sub-module: alu4 is the existing combinational ALU, instantiated once, fed directly from req_op/req_a/req_b.
- FIFO storage, pointers and counters live inline in alu4_exec_unit.

Test Plan:
1. Reset then idle → req_ready=1, rsp_valid=0, op_count=0, ovf_sticky=0. Assert reset_n=0 asynchronously mid-cycle → outputs clear immediately.
2. Run each opcode with rsp_ready=1, one check per opcode:
   - NOT A a=0000 → 1111, n=1 z=0.
   - AND 0101&1010 → 0000, z=1.
   - XNOR 0101,0011 → 1001.
   - ADD 0101+0011 → 1000, c=0 n=1 v=1 (ovf_sticky then 1).
   - SUB 0101−0010 → 0011, c=1 v=0.
   - SUB 0010−0101 → 1101, c=0 n=1 v=0.
   - Each response appears one cycle after accept.
3. Backpressure, DEPTH=2, rsp_ready=0: send ADD 0001+0001, OR 1100|0011, XOR 1111^0101.
   - First two are accepted and req_ready drops to 0; the third is held.
   - Raise rsp_ready → responses 0010, 1111, 1010 in order, with the third accepted only after a pop.
4. Streaming: 16 back-to-back ADDs with rsp_ready=1 → one response per cycle, count never exceeds 1, op_count=16.
5. Stall hold: response head 1000 with rsp_ready=0 for 5 cycles while req_a/req_b toggle → rsp_result stays 1000 with flags unchanged.
6. Wrap: 256 accepts with CNT_W=8 → op_count returns to 0. FIFO pointers wrap with no lost or duplicated responses (scoreboard compare).
